// File: rtl/fwrisc_ifetch_prefetch.sv
// Instruction prefetch buffer between the fwrisc core fetch port and a
// single-cycle-latency instruction SRAM. Streams sequential words into a
// small FIFO; a mismatched request redirects the stream.
module fwrisc_ifetch_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           iaddr,
    input  logic                  ivalid,
    output logic                  iready,
    output logic [31:0]           idata,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic                  mren,
    input  logic [31:0]           mrdata,
    output logic [31:0]           ack_count,
    output logic [31:0]           redirect_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_WORD = RESET_ADDR[ADDR_WIDTH+1:2];

    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [DEPTH];
    logic [31:0]           fifo_data_q [DEPTH];
    logic [31:0]           fifo_data_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_WIDTH-1:0] inf_addr_q, inf_addr_d;
    logic                  inf_v_q, inf_v_d;
    logic [31:0]           ack_count_q, ack_count_d;
    logic [31:0]           redirect_count_q, redirect_count_d;

    logic [ADDR_WIDTH-1:0] req_word_c;
    logic [CNT_W:0]        occupancy_c;
    logic                  fifo_empty_c;
    logic                  hit_c;
    logic                  bypass_c;
    logic                  redirect_c;
    logic                  issue_c;
    logic                  ack_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  unused_iaddr_c;

    // Only the word-address bits of iaddr take part in the compare
    assign req_word_c     = iaddr[ADDR_WIDTH+1:2];
    assign unused_iaddr_c = ^{iaddr[31:ADDR_WIDTH+2], iaddr[1:0]};

    // Request classification: head hit, in-flight bypass, redirect, sequential issue
    always_comb begin
        fifo_empty_c = (count_q == '0);
        occupancy_c  = {1'b0, count_q} + (CNT_W+1)'(inf_v_q);
        hit_c        = ivalid && !fifo_empty_c && (fifo_addr_q[rd_ptr_q] == req_word_c);
        bypass_c     = ivalid && fifo_empty_c && inf_v_q && (inf_addr_q == req_word_c);
        redirect_c   = ivalid && !flush && !hit_c && !bypass_c;
        issue_c      = !flush && !redirect_c && (occupancy_c < (CNT_W+1)'(DEPTH));
        ack_c        = !flush && (hit_c || bypass_c);
        pop_c        = ack_c && hit_c;
        push_c       = !flush && !redirect_c && inf_v_q && !bypass_c;
    end

    // Core and SRAM side outputs; forced idle while reset is asserted
    always_comb begin
        iready = 1'b0;
        idata  = '0;
        mren   = 1'b0;
        maddr  = fetch_ptr_q;
        if (reset_n) begin
            iready = ack_c;
            if (hit_c && ack_c) begin
                idata = fifo_data_q[rd_ptr_q];
            end else if (bypass_c && ack_c) begin
                idata = mrdata;
            end
            mren = redirect_c || issue_c;
            if (redirect_c) begin
                maddr = req_word_c;
            end
        end
    end

    assign ack_count      = ack_count_q;
    assign redirect_count = redirect_count_q;

    // Next-state: flush beats redirect beats normal push/pop/issue
    always_comb begin
        fifo_addr_d      = fifo_addr_q;
        fifo_data_d      = fifo_data_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        fetch_ptr_d      = fetch_ptr_q;
        inf_addr_d       = inf_addr_q;
        inf_v_d          = inf_v_q;
        ack_count_d      = ack_count_q + 32'(ack_c);
        redirect_count_d = redirect_count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            inf_v_d  = 1'b0;
        end else if (redirect_c) begin
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
            inf_v_d          = 1'b1;
            inf_addr_d       = req_word_c;
            fetch_ptr_d      = req_word_c + ADDR_WIDTH'(1);
            redirect_count_d = redirect_count_q + 32'd1;
        end else begin
            if (push_c) begin
                fifo_addr_d[wr_ptr_q] = inf_addr_q;
                fifo_data_d[wr_ptr_q] = mrdata;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (issue_c) begin
                inf_v_d     = 1'b1;
                inf_addr_d  = fetch_ptr_q;
                fetch_ptr_d = fetch_ptr_q + ADDR_WIDTH'(1);
            end else begin
                inf_v_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_addr_q      <= '{default: '0};
            fifo_data_q      <= '{default: '0};
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            fetch_ptr_q      <= RESET_WORD;
            inf_addr_q       <= '0;
            inf_v_q          <= 1'b0;
            ack_count_q      <= '0;
            redirect_count_q <= '0;
        end else begin
            fifo_addr_q      <= fifo_addr_d;
            fifo_data_q      <= fifo_data_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            fetch_ptr_q      <= fetch_ptr_d;
            inf_addr_q       <= inf_addr_d;
            inf_v_q          <= inf_v_d;
            ack_count_q      <= ack_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

endmodule

// File: tb/tb_fwrisc_ifetch_prefetch.sv
// Bench for fwrisc_ifetch_prefetch: directed scenarios plus a randomized
// request stream checked against a queue-based fetch model.
module tb_fwrisc_ifetch_prefetch;

    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   iaddr, iaddr2;
    logic          ivalid, ivalid2;
    logic          flush, flush2;
    logic          iready, iready2;
    logic [31:0]   idata, idata2;
    logic [AW-1:0] maddr, maddr2;
    logic          mren, mren2;
    logic [31:0]   mrdata = 32'h0;
    logic [31:0]   mrdata2 = 32'h0;
    logic [31:0]   ack_count, ack_count2;
    logic [31:0]   redirect_count, redirect_count2;

    int total;
    int bad;

    fwrisc_ifetch_prefetch #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESET_ADDR(32'h0)) dut (
        .clock(clock), .reset_n(reset_n), .iaddr(iaddr), .ivalid(ivalid),
        .iready(iready), .idata(idata), .flush(flush), .maddr(maddr),
        .mren(mren), .mrdata(mrdata), .ack_count(ack_count),
        .redirect_count(redirect_count)
    );

    fwrisc_ifetch_prefetch #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESET_ADDR(32'hFFFC)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .iaddr(iaddr2), .ivalid(ivalid2),
        .iready(iready2), .idata(idata2), .flush(flush2), .maddr(maddr2),
        .mren(mren2), .mrdata(mrdata2), .ack_count(ack_count2),
        .redirect_count(redirect_count2)
    );

    always #5 clock = ~clock;

    // SRAM contents: word n holds n
    function automatic logic [31:0] mem(input logic [AW-1:0] w);
        return 32'(w);
    endfunction

    always @(posedge clock) begin
        if (mren)  mrdata  <= mem(maddr);
        if (mren2) mrdata2 <= mem(maddr2);
    end

    // Reference model: queue of buffered word addresses plus one outstanding read
    logic [AW-1:0] m_fifo[$];
    logic [AW-1:0] m_ptr;
    logic [AW-1:0] m_infa;
    bit            m_infv;
    logic [31:0]   m_ack;
    logic [31:0]   m_redir;
    bit            e_iready, e_mren, last_ack;
    logic [31:0]   e_idata;
    logic [AW-1:0] e_maddr;

    logic          s_iready, s_mren, s2_iready, s2_mren;
    logic [31:0]   s_idata, s2_idata;
    logic [AW-1:0] s_maddr, s2_maddr;

    task automatic m_reset();
        m_fifo.delete();
        m_ptr   = '0;
        m_infa  = '0;
        m_infv  = 0;
        m_ack   = '0;
        m_redir = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] a, input bit f);
        logic [AW-1:0] w;
        bit hit, byp, redir, issue;
        int occ;
        w     = a[AW+1:2];
        occ   = m_fifo.size() + int'(m_infv);
        hit   = v && (m_fifo.size() > 0) && (m_fifo[0] == w);
        byp   = v && (m_fifo.size() == 0) && m_infv && (m_infa == w);
        redir = v && !f && !hit && !byp;
        issue = !f && !redir && (occ < DEPTH);
        e_iready = !f && (hit || byp);
        e_idata  = '0;
        if (e_iready) e_idata = hit ? mem(m_fifo[0]) : mem(m_infa);
        e_mren  = redir || issue;
        e_maddr = redir ? w : m_ptr;
        if (e_iready) m_ack = m_ack + 1;
        if (f) begin
            m_fifo.delete();
            m_infv = 0;
        end else if (redir) begin
            m_fifo.delete();
            m_infv  = 1;
            m_infa  = w;
            m_ptr   = w + AW'(1);
            m_redir = m_redir + 1;
        end else begin
            if (hit) void'(m_fifo.pop_front());
            if (m_infv && !byp) m_fifo.push_back(m_infa);
            if (issue) begin
                m_infa = m_ptr;
                m_ptr  = m_ptr + AW'(1);
                m_infv = 1;
            end else begin
                m_infv = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample at falling edge, check against model
    task automatic cycle(input logic v, input logic [31:0] a, input logic f);
        ivalid = v;
        iaddr  = a;
        flush  = f;
        @(negedge clock);
        s_iready  = iready;  s_idata  = idata;  s_mren  = mren;  s_maddr  = maddr;
        s2_iready = iready2; s2_idata = idata2; s2_mren = mren2; s2_maddr = maddr2;
        chk("ack_count", ack_count, m_ack);
        chk("redirect_count", redirect_count, m_redir);
        model_step(v, a, f);
        chk("iready", 32'(s_iready), 32'(e_iready));
        if (e_iready) chk("idata", s_idata, e_idata);
        chk("mren", 32'(s_mren), 32'(e_mren));
        if (e_mren) chk("maddr", 32'(s_maddr), 32'(e_maddr));
        last_ack = e_iready;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit          rv;
        logic [31:0] ra;
        bit          rf;
        int          r;
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        ivalid = 1'b0; iaddr = '0; flush = 1'b0;
        ivalid2 = 1'b0; iaddr2 = '0; flush2 = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_iready", 32'(iready), 32'd0);
        chk("rst_mren", 32'(mren), 32'd0);
        chk("rst_idata", idata, 32'd0);
        chk("rst_maddr", 32'(maddr), 32'h0);
        chk("rst_ack_count", ack_count, 32'd0);
        chk("rst_redirect_count", redirect_count, 32'd0);
        chk("rst_wrap_maddr", 32'(maddr2), 32'h3FFF);
        reset_n = 1'b1;

        // First read right after reset release; wrap instance crosses 0x3FFF -> 0
        cycle(1'b0, 32'h0, 1'b0);
        chk("first_mren", 32'(s_mren), 32'd1);
        chk("first_maddr", 32'(s_maddr), 32'h0);
        chk("wrap_maddr0", 32'(s2_maddr), 32'h3FFF);
        chk("wrap_mren0", 32'(s2_mren), 32'd1);
        cycle(1'b0, 32'h0, 1'b0);
        chk("wrap_maddr1", 32'(s2_maddr), 32'h0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0);

        // Sequential stream
        for (int k = 0; k < 12; k++) begin
            ivalid2 = (k < 2);
            iaddr2  = (k == 0) ? 32'h0000_FFFC : 32'h0001_0000;
            cycle(1'b1, 32'(k * 4), 1'b0);
            chk("stream_iready", 32'(s_iready), 32'd1);
            chk("stream_idata", s_idata, 32'(k));
            if (k >= 1) chk("stream_mren", 32'(s_mren), 32'd1);
            if (k == 0) chk("wrap_idata0", s2_idata, 32'h3FFF);
            if (k == 1) chk("wrap_idata1", s2_idata, 32'h0);
            if (k < 2) chk("wrap_iready", 32'(s2_iready), 32'd1);
        end
        ivalid2 = 1'b0;
        chk("stream_redirects", redirect_count, 32'd0);
        chk("wrap_redirects", redirect_count2, 32'd0);

        // Branch
        cycle(1'b1, 32'h100, 1'b0);
        chk("br_mren", 32'(s_mren), 32'd1);
        chk("br_maddr", 32'(s_maddr), 32'h40);
        chk("br_iready0", 32'(s_iready), 32'd0);
        chk("br_redirect_count", redirect_count, 32'd1);
        cycle(1'b1, 32'h100, 1'b0);
        chk("br_iready1", 32'(s_iready), 32'd1);
        chk("br_idata1", s_idata, 32'h40);
        cycle(1'b1, 32'h104, 1'b0);
        chk("br_iready2", 32'(s_iready), 32'd1);
        chk("br_idata2", s_idata, 32'h41);

        // Flush with request held at 0x20
        cycle(1'b1, 32'h20, 1'b1);
        chk("fl_iready", 32'(s_iready), 32'd0);
        chk("fl_mren", 32'(s_mren), 32'd0);
        cycle(1'b1, 32'h20, 1'b0);
        chk("fl_redir_mren", 32'(s_mren), 32'd1);
        chk("fl_redir_maddr", 32'(s_maddr), 32'h8);
        chk("fl_redir_iready", 32'(s_iready), 32'd0);
        cycle(1'b1, 32'h20, 1'b0);
        chk("fl_ack_iready", 32'(s_iready), 32'd1);
        chk("fl_ack_idata", s_idata, 32'h8);

        // Randomized request stream; requests held until acknowledged
        rv = 0;
        ra = 32'h20;
        last_ack = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!rv || last_ack) begin
                r = int'($urandom_range(0, 99));
                if (r < 15) begin
                    rv = 0;
                end else begin
                    rv = 1;
                    if (r < 75)      ra = ra + 32'd4;
                    else if (r < 92) ra = 32'($urandom_range(0, 255)) << 2;
                    else             ra = $urandom();
                end
            end
            rf = ($urandom_range(0, 99) < 3);
            cycle(rv, ra, rf);
        end

        // Asynchronous reset between clock edges with a request pending
        cycle(1'b1, 32'h200, 1'b0);
        cycle(1'b1, 32'h200, 1'b0);
        cycle(1'b1, 32'h204, 1'b0);
        ivalid = 1'b1;
        iaddr  = 32'h208;
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_mren", 32'(mren), 32'd0);
        chk("ar_iready", 32'(iready), 32'd0);
        chk("ar_ack_count", ack_count, 32'd0);
        chk("ar_redirect_count", redirect_count, 32'd0);
        m_reset();
        ivalid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Backpressure: ten idle cycles then four back-to-back hits
        cycle(1'b0, 32'h0, 1'b0);
        chk("bp_restart_mren", 32'(s_mren), 32'd1);
        chk("bp_restart_maddr", 32'(s_maddr), 32'h0);
        repeat (9) cycle(1'b0, 32'h0, 1'b0);
        chk("bp_mren_stalled", 32'(s_mren), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'(k * 4), 1'b0);
            chk("bp_iready", 32'(s_iready), 32'd1);
            chk("bp_idata", s_idata, 32'(k));
        end
        chk("bp_redirects", redirect_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
